instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 16-bit program-memory words; legal range 2..256.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 load_en  input  1  SHALL request a program load; its rising edge starts a load, and low ends it.
REQ-005 byte_valid  input  1  SHALL mark byte_data as valid this cycle.
REQ-006 byte_data  input  8  SHALL carry one program byte, high byte of each word first.
REQ-007 byte_ready  output  1  SHALL indicate the loader accepts a byte this cycle.
REQ-008 mem_we  output  1  SHALL be a one-cycle write strobe to program memory.
REQ-009 mem_waddr  output  8  SHALL be the word address for mem_we.
REQ-010 mem_wdata  output  16  SHALL be the assembled word for mem_we.
REQ-011 word_count  output  9  SHALL count words written in the current or last load.
REQ-012 cpu_hold  output  1  SHALL hold the CPU sequencer stopped while high.
REQ-013 load_done  output  1  SHALL flag a completed or terminated load.
REQ-014 checksum  output  16  SHALL present the running word checksum (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, HI, LO, WR, DONE.
REQ-016 A byte SHALL transfer only in a cycle where byte_valid and byte_ready are both high; byte_ready SHALL be high only in HI and LO with load_en high.
REQ-017 IDLE or DONE, load_en rising edge: go to HI; clear write address, word_count and checksum; drop load_done.
REQ-018 HI, transfer: latch byte as bits 15:8, go to LO.
REQ-019 LO, transfer: latch byte as bits 7:0, go to WR.
REQ-020 WR: mem_we high exactly one cycle with current address and assembled word; address and word_count increment by 1 in the same cycle.
REQ-021 WR, address == DEPTH-1: go to DONE; otherwise go to HI.
REQ-022 Address SHALL NOT wrap; at most DEPTH words are written per load.
REQ-023 load_en low in HI or LO: go to DONE; a partial word (high byte only) SHALL be discarded, with no write.
REQ-024 load_en low in WR: the write SHALL complete, then go to DONE.
REQ-025 Input-valid bytes in WR, IDLE or DONE SHALL be ignored (ready low).
REQ-026 cpu_hold SHALL be high in IDLE, HI, LO and WR, and low only in DONE.
REQ-027 load_done SHALL be high only in DONE.
REQ-028 A load_en level held high across DONE SHALL NOT restart a load; only a new rising edge restarts.
REQ-029 Minimum throughput SHALL be one word per 3 cycles; byte-accept-to-mem_we latency SHALL be 1 cycle after the low byte.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, address 0, word_count 0, checksum 0, mem_we 0, byte_ready 0, load_done 0, cpu_hold 1, mem_wdata 0, mem_waddr 0.
REQ-031 Reset mid-load SHALL abort without a write; the load_en edge detector SHALL reset to "previous low".

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN defined: checksum SHALL be the XOR of all words written this load, updated in the WR cycle and cleared on load start.
REQ-033 Macro LOADER_CHECKSUM_EN undefined: checksum SHALL be tied to 0 and no checksum register is built; all other behaviour identical.

Verification
REQ-034 Reset, then raise load_en and stream bytes 12 34 AB CD; drop load_en -> writes 0x1234 @0 and 0xABCD @1, word_count 2, load_done 1, cpu_hold 0, checksum 0xB9F9 (0 if macro off).
REQ-035 DEPTH=4, send 10 bytes continuously -> exactly 4 writes at addresses 0..3, DONE after address 3, remaining 2 bytes never see ready.
REQ-036 Send byte 0x55 then drop load_en -> no mem_we, word_count 0, load_done 1.
REQ-037 byte_valid toggled 1/0 each cycle over bytes 01 02 -> single write 0x0102 @0; a WR-cycle valid byte 0xFF is not consumed.
REQ-038 Assert rst_n low during LO after 0x77 -> no write, cpu_hold 1; a new load_en edge then writes from address 0.
REQ-039 Hold load_en high after DONE for 10 cycles -> stays in DONE; low then high -> word_count and checksum cleared, load restarts.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words into program memory while holding the CPU.
// Optional word checksum enabled by defining LOADER_CHECKSUM_EN.
module instr_loader #(
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [7:0]  mem_waddr,
    output logic [15:0] mem_wdata,
    output logic [8:0]  word_count,
    output logic        cpu_hold,
    output logic        load_done,
    output logic [15:0] checksum
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 9;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_load_en_q;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [BW-1:0] r_hi;
    logic [BW-1:0] w_hi_nxt;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] w_wdata_nxt;
    logic          r_mem_we;
    logic          r_cpu_hold;
    logic          r_load_done;
    logic          w_rise;
    logic          w_ready;
    logic          w_xfer;

    assign w_rise  = load_en & ~r_load_en_q;
    assign w_ready = load_en & ((r_state == S_HI) | (r_state == S_LO));
    assign w_xfer  = w_ready & byte_valid;

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_count_nxt = r_count;
        w_hi_nxt    = r_hi;
        w_wdata_nxt = r_wdata;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_rise) begin
                    w_state_nxt = S_HI;
                    w_addr_nxt  = '0;
                    w_count_nxt = '0;
                end
            end
            S_HI: begin
                if (!load_en) begin
                    w_state_nxt = S_DONE;
                end else if (w_xfer) begin
                    w_hi_nxt    = byte_data;
                    w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                if (!load_en) begin
                    w_state_nxt = S_DONE;
                end else if (w_xfer) begin
                    w_wdata_nxt = {r_hi, byte_data};
                    w_state_nxt = S_WR;
                end
            end
            S_WR: begin
                w_count_nxt = r_count + CW'(1);
                // Address saturates at the last word so it never wraps
                if ((r_addr == LAST_ADDR) || !load_en) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_addr_nxt  = r_addr + AW'(1);
                    w_state_nxt = S_HI;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_load_en_q <= 1'b0;
            r_addr      <= '0;
            r_count     <= '0;
            r_hi        <= '0;
            r_wdata     <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_en_q <= load_en;
            r_addr      <= w_addr_nxt;
            r_count     <= w_count_nxt;
            r_hi        <= w_hi_nxt;
            r_wdata     <= w_wdata_nxt;
            r_mem_we    <= (w_state_nxt == S_WR);
            r_cpu_hold  <= (w_state_nxt != S_DONE);
            r_load_done <= (w_state_nxt == S_DONE);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic          w_start;
    logic [DW-1:0] r_checksum;

    assign w_start = w_rise & ((r_state == S_IDLE) | (r_state == S_DONE));

    // XOR of every word written this load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (r_state == S_WR) begin
            r_checksum <= r_checksum ^ r_wdata;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign byte_ready = w_ready;
    assign mem_we     = r_mem_we;
    assign mem_waddr  = r_addr;
    assign mem_wdata  = r_wdata;
    assign word_count = r_count;
    assign cpu_hold   = r_cpu_hold;
    assign load_done  = r_load_done;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: behavioural load model predicts writes and status, monitor checks them.
module tb_instr_loader;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic [8:0]  word_count;
    logic        cpu_hold;
    logic        load_done;
    logic [15:0] checksum;

    int n_tests = 0;
    int n_fail  = 0;

    instr_loader #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .word_count(word_count),
        .cpu_hold(cpu_hold), .load_done(load_done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a load is a sequence of byte pairs, each pair becomes one write the cycle after
    bit          m_active  = 1'b0;
    bit          m_have_hi = 1'b0;
    bit          m_wr      = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_prev_le = 1'b0;
    int          m_addr    = 0;
    int          m_count   = 0;
    int          m_acc     = 0;
    logic [7:0]  m_hi      = 8'h00;
    logic [15:0] m_word    = 16'h0000;
    logic [15:0] m_csum    = 16'h0000;
    logic [23:0] exp_q[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_active = 0; m_have_hi = 0; m_wr = 0; m_done = 0; m_prev_le = 0;
            m_addr = 0; m_count = 0; m_csum = 16'h0000;
            exp_q.delete();
        end else begin
            if (m_wr) begin
                m_wr = 0;
                m_count++;
                m_csum = m_csum ^ m_word;
                if (m_addr == int'(DEPTH) - 1 || !load_en) begin
                    m_active = 0; m_done = 1;
                end else begin
                    m_addr++;
                end
            end else if (m_active) begin
                if (!load_en) begin
                    m_active = 0; m_done = 1; m_have_hi = 0;
                end else if (byte_valid) begin
                    m_acc++;
                    if (!m_have_hi) begin
                        m_hi = byte_data; m_have_hi = 1;
                    end else begin
                        m_word = {m_hi, byte_data};
                        exp_q.push_back({8'(m_addr), m_word});
                        m_have_hi = 0; m_wr = 1;
                    end
                end
            end else if (load_en && !m_prev_le) begin
                m_active = 1; m_done = 0; m_have_hi = 0;
                m_addr = 0; m_count = 0; m_csum = 16'h0000;
            end
            m_prev_le = load_en;
        end
    end

    // Monitor: status every cycle, writes popped from the scoreboard
    int          n_writes  = 0;
    logic [7:0]  last_addr = 8'h00;
    logic [15:0] last_data = 16'h0000;

    initial forever begin
        logic [23:0] e;
        logic [15:0] exp_cs;
        @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
        exp_cs = m_csum;
`else
        exp_cs = 16'h0000;
`endif
        chk("byte_ready", 32'(byte_ready), 32'(m_active && !m_wr && load_en));
        chk("mem_we", 32'(mem_we), 32'(m_wr));
        chk("cpu_hold", 32'(cpu_hold), 32'(!m_done));
        chk("load_done", 32'(load_done), 32'(m_done));
        chk("word_count", 32'(word_count), 32'(m_count));
        chk("checksum", 32'(checksum), 32'(exp_cs));
        if (mem_we) begin
            n_writes++;
            last_addr = mem_waddr;
            last_data = mem_wdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 32'(mem_waddr), 32'(e[23:16]));
                chk("wdata", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
    end

    task automatic cyc(input logic le, input logic v, input logic [7:0] d);
        load_en = le; byte_valid = v; byte_data = d;
        @(posedge clk); #1;
    endtask

    // Present one byte until the model reports it consumed; toggle=1 alternates valid each cycle
    task automatic send(input logic [7:0] b, input bit toggle);
        int start;
        int k;
        start = m_acc;
        k = 0;
        byte_data = b;
        while (m_acc == start && k < 30) begin
            byte_valid = toggle ? ~byte_valid : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        chk("send_timeout", 32'(m_acc != start), 32'(1));
    endtask

    initial begin
        int w0;
        int a0;
        bit le;

        // Reset state
        @(negedge clk);
        chk("rst_waddr", 32'(mem_waddr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'h1);
        chk("rst_ready", 32'(byte_ready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 8'h00);

        // Two-word load
        w0 = n_writes;
        load_en = 1'b1;
        send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
        cyc(1, 0, 8'h00); cyc(1, 0, 8'h00); cyc(0, 0, 8'h00);
        @(negedge clk);
        chk("basic_writes", 32'(n_writes - w0), 32'd2);
        chk("basic_last_addr", 32'(last_addr), 32'h1);
        chk("basic_last_data", 32'(last_data), 32'hABCD);
        chk("basic_count", 32'(word_count), 32'd2);
        chk("basic_done", 32'(load_done), 32'h1);
        chk("basic_hold", 32'(cpu_hold), 32'h0);
`ifdef LOADER_CHECKSUM_EN
        chk("basic_checksum", 32'(checksum), 32'hB9F9);
`else
        chk("basic_checksum", 32'(checksum), 32'h0);
`endif
        @(posedge clk); #1;

        // Overrun: continuous bytes past DEPTH words
        cyc(0, 0, 8'h00);
        w0 = n_writes; a0 = m_acc;
        for (int i = 0; i < 20; i++) cyc(1, 1, 8'(8'h40 + 8'(m_acc - a0)));
        cyc(0, 0, 8'h00);
        @(negedge clk);
        chk("depth_writes", 32'(n_writes - w0), 32'd4);
        chk("depth_accepted", 32'(m_acc - a0), 32'd8);
        chk("depth_last_addr", 32'(last_addr), 32'h3);
        chk("depth_count", 32'(word_count), 32'd4);
        @(posedge clk); #1;

        // Partial word discarded
        cyc(0, 0, 8'h00);
        w0 = n_writes;
        load_en = 1'b1;
        send(8'h55, 0);
        cyc(0, 0, 8'h00); cyc(0, 0, 8'h00);
        @(negedge clk);
        chk("partial_writes", 32'(n_writes - w0), 32'd0);
        chk("partial_count", 32'(word_count), 32'd0);
        chk("partial_done", 32'(load_done), 32'h1);
        @(posedge clk); #1;

        // Toggled valid, WR-cycle byte ignored
        cyc(0, 0, 8'h00);
        w0 = n_writes; a0 = m_acc;
        load_en = 1'b1;
        send(8'h01, 1); send(8'h02, 1);
        cyc(1, 1, 8'hFF); cyc(0, 1, 8'hFF); cyc(0, 0, 8'h00);
        @(negedge clk);
        chk("toggle_writes", 32'(n_writes - w0), 32'd1);
        chk("toggle_data", 32'(last_data), 32'h0102);
        chk("toggle_addr", 32'(last_addr), 32'h0);
        chk("toggle_accepted", 32'(m_acc - a0), 32'd2);
        @(posedge clk); #1;

        // Reset during LO
        cyc(0, 0, 8'h00);
        w0 = n_writes;
        load_en = 1'b1;
        send(8'h77, 0);
        rst_n = 1'b0; load_en = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        chk("midrst_hold", 32'(cpu_hold), 32'h1);
        chk("midrst_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 8'h00);
        load_en = 1'b1;
        send(8'hA1, 0); send(8'hB2, 0);
        cyc(1, 0, 8'h00); cyc(0, 0, 8'h00);
        @(negedge clk);
        chk("midrst_writes", 32'(n_writes - w0), 32'd1);
        chk("midrst_addr", 32'(last_addr), 32'h0);
        chk("midrst_data", 32'(last_data), 32'hA1B2);
        @(posedge clk); #1;

        // load_en held high through DONE, then a fresh edge
        cyc(0, 0, 8'h00);
        load_en = 1'b1;
        for (int i = 0; i < 8; i++) send(8'(i * 17 + 3), 0);
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'h00);
        @(negedge clk);
        chk("hold_done", 32'(load_done), 32'h1);
        chk("hold_cpu", 32'(cpu_hold), 32'h0);
        chk("hold_count", 32'(word_count), 32'd4);
        @(posedge clk); #1;
        cyc(0, 0, 8'h00); cyc(1, 0, 8'h00);
        @(negedge clk);
        chk("restart_count", 32'(word_count), 32'd0);
        chk("restart_checksum", 32'(checksum), 32'h0);
        chk("restart_done", 32'(load_done), 32'h0);
        chk("restart_hold", 32'(cpu_hold), 32'h1);
        @(posedge clk); #1;
        cyc(0, 0, 8'h00);

        // Randomized traffic
        le = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 11) == 0) le = ~le;
            cyc(le, 1'($urandom_range(0, 9) < 7), 8'($urandom));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
